// File: rtl/inverse_kinematics.sv
// Mecanum inverse kinematics: (vx, vy, wz) -> w1..w4 in sign-magnitude Q format, one shared serial multiplier.
// Latency 157 clocks from the Start-sampling edge to Done. Start is ignored while busy, and requests are not queued.
module inverse_kinematics #(
  parameter int                 N_WIDTH = 32,
  parameter int                 Q_WIDTH = 15,
  parameter logic [N_WIDTH-1:0] K_LXLY  = 32'd6554,
  parameter logic [N_WIDTH-1:0] INV_R   = 32'd900219
) (
  input  logic               INVERSE_KINEMATICS_CLOCK_50,
  input  logic               INVERSE_KINEMATICS_Reset_InHigh,
  input  logic               INVERSE_KINEMATICS_Start_InHigh,
  input  logic [N_WIDTH-1:0] INVERSE_KINEMATICS_VX_InBus,
  input  logic [N_WIDTH-1:0] INVERSE_KINEMATICS_VY_InBus,
  input  logic [N_WIDTH-1:0] INVERSE_KINEMATICS_WZ_InBus,
  output logic [N_WIDTH-1:0] INVERSE_KINEMATICS_W1_OutBus,
  output logic [N_WIDTH-1:0] INVERSE_KINEMATICS_W2_OutBus,
  output logic [N_WIDTH-1:0] INVERSE_KINEMATICS_W3_OutBus,
  output logic [N_WIDTH-1:0] INVERSE_KINEMATICS_W4_OutBus,
  output logic               INVERSE_KINEMATICS_Busy_OutHigh,
  output logic               INVERSE_KINEMATICS_Done_OutHigh,
  output logic               INVERSE_KINEMATICS_Overflow_OutHigh
);

  localparam int              MW       = N_WIDTH - 1;
  localparam int              PW       = 2 * MW;
  localparam int              CW       = $clog2(MW);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MW - 1);
  localparam logic [MW-1:0]   MAG_MAX  = {MW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_K, S_ADD, S_MUL_W1, S_MUL_W2, S_MUL_W3, S_MUL_W4, S_DONE
  } state_t;

  logic               clk;
  logic               rst;
  logic               start;
  state_t             state, state_nxt;

  logic [N_WIDTH-1:0] vx_r, vy_r, t_r;
  logic [N_WIDTH-1:0] s2_r, s3_r, s4_r;
  logic [N_WIDTH-1:0] r1_r, r2_r, r3_r;
  logic               ovf_acc;

  logic [PW-1:0]      mul_a, mul_acc, mul_acc_nxt;
  logic [MW-1:0]      mul_b, mul_mag;
  logic [CW-1:0]      mul_cnt;
  logic               mul_sign, mul_sat, mul_last, mul_run, mul_ld;
  logic [N_WIDTH-1:0] mul_res, mul_op, mul_k;
  logic [Q_WIDTH-1:0] frac_unused;

  logic [N_WIDTH:0]   a_sum, a_dif, a1, a2, a3, a4;
  logic               add_ovf;

  logic [N_WIDTH-1:0] w1_q, w2_q, w3_q, w4_q;
  logic               busy_q, done_q, ovf_q;

  assign clk   = INVERSE_KINEMATICS_CLOCK_50;
  assign rst   = INVERSE_KINEMATICS_Reset_InHigh;
  assign start = INVERSE_KINEMATICS_Start_InHigh;

  // Returns {overflow, sign, magnitude}; a zero magnitude always comes back positive.
  function automatic logic [N_WIDTH:0] sm_add(input logic [N_WIDTH-1:0] a,
                                              input logic [N_WIDTH-1:0] b);
    logic [MW:0]   sum;
    logic [MW-1:0] mag;
    logic          sgn;
    logic          ovf;
    sum = '0;
    mag = '0;
    sgn = 1'b0;
    ovf = 1'b0;
    if (a[MW] == b[MW]) begin
      sum = {1'b0, a[MW-1:0]} + {1'b0, b[MW-1:0]};
      sgn = a[MW];
      if (sum[MW]) begin
        mag = MAG_MAX;
        ovf = 1'b1;
      end else begin
        mag = sum[MW-1:0];
      end
    end else if (a[MW-1:0] >= b[MW-1:0]) begin
      mag = a[MW-1:0] - b[MW-1:0];
      sgn = a[MW];
    end else begin
      mag = b[MW-1:0] - a[MW-1:0];
      sgn = b[MW];
    end
    if (mag == '0) sgn = 1'b0;
    return {ovf, sgn, mag};
  endfunction

  function automatic logic [N_WIDTH-1:0] sm_neg(input logic [N_WIDTH-1:0] a);
    return {~a[MW], a[MW-1:0]};
  endfunction

  // One multiplier bit per cycle; the final step's sum is truncated by Q and saturated here.
  always_comb begin
    mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);
    mul_sat     = |mul_acc_nxt[PW-1:Q_WIDTH+MW];
    mul_mag     = mul_sat ? MAG_MAX : mul_acc_nxt[Q_WIDTH+MW-1:Q_WIDTH];
    mul_res     = {mul_sign & (|mul_mag), mul_mag};
    mul_last    = (mul_cnt == CNT_LAST);
  end

  assign frac_unused = mul_acc_nxt[Q_WIDTH-1:0];

  always_comb begin
    a_sum   = sm_add(vx_r, vy_r);
    a_dif   = sm_add(vx_r, sm_neg(vy_r));
    a1      = sm_add(a_dif[N_WIDTH-1:0], sm_neg(t_r));
    a2      = sm_add(a_sum[N_WIDTH-1:0], t_r);
    a3      = sm_add(a_sum[N_WIDTH-1:0], sm_neg(t_r));
    a4      = sm_add(a_dif[N_WIDTH-1:0], t_r);
    add_ovf = a_sum[N_WIDTH] | a_dif[N_WIDTH] | a1[N_WIDTH] |
              a2[N_WIDTH] | a3[N_WIDTH] | a4[N_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A load on the last step of one product overrides the step and starts the next.
  always_comb begin
    state_nxt = state;
    mul_ld    = 1'b0;
    mul_run   = 1'b0;
    mul_op    = '0;
    mul_k     = INV_R;
    unique case (state)
      S_IDLE: begin
        mul_k  = K_LXLY;
        mul_op = INVERSE_KINEMATICS_WZ_InBus;
        if (start) begin
          state_nxt = S_MUL_K;
          mul_ld    = 1'b1;
        end
      end
      S_MUL_K: begin
        mul_run = 1'b1;
        if (mul_last) state_nxt = S_ADD;
      end
      S_ADD: begin
        mul_ld    = 1'b1;
        mul_op    = a1[N_WIDTH-1:0];
        state_nxt = S_MUL_W1;
      end
      S_MUL_W1: begin
        mul_run = 1'b1;
        mul_op  = s2_r;
        if (mul_last) begin
          mul_ld    = 1'b1;
          state_nxt = S_MUL_W2;
        end
      end
      S_MUL_W2: begin
        mul_run = 1'b1;
        mul_op  = s3_r;
        if (mul_last) begin
          mul_ld    = 1'b1;
          state_nxt = S_MUL_W3;
        end
      end
      S_MUL_W3: begin
        mul_run = 1'b1;
        mul_op  = s4_r;
        if (mul_last) begin
          mul_ld    = 1'b1;
          state_nxt = S_MUL_W4;
        end
      end
      S_MUL_W4: begin
        mul_run = 1'b1;
        if (mul_last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx_r     <= '0;
      vy_r     <= '0;
      t_r      <= '0;
      s2_r     <= '0;
      s3_r     <= '0;
      s4_r     <= '0;
      r1_r     <= '0;
      r2_r     <= '0;
      r3_r     <= '0;
      ovf_acc  <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_acc  <= '0;
      mul_cnt  <= '0;
      mul_sign <= 1'b0;
      w1_q     <= '0;
      w2_q     <= '0;
      w3_q     <= '0;
      w4_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_nxt != S_IDLE);

      if (mul_ld) begin
        mul_acc  <= '0;
        mul_a    <= {{MW{1'b0}}, mul_op[MW-1:0]};
        mul_b    <= mul_k[MW-1:0];
        mul_sign <= mul_op[MW] ^ mul_k[MW];
        mul_cnt  <= '0;
      end else if (mul_run) begin
        mul_acc  <= mul_acc_nxt;
        mul_a    <= mul_a << 1;
        mul_b    <= mul_b >> 1;
        mul_cnt  <= mul_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            vx_r    <= INVERSE_KINEMATICS_VX_InBus;
            vy_r    <= INVERSE_KINEMATICS_VY_InBus;
            ovf_acc <= 1'b0;
          end
        end
        S_MUL_K: begin
          if (mul_last) begin
            t_r     <= mul_res;
            ovf_acc <= ovf_acc | mul_sat;
          end
        end
        S_ADD: begin
          s2_r    <= a2[N_WIDTH-1:0];
          s3_r    <= a3[N_WIDTH-1:0];
          s4_r    <= a4[N_WIDTH-1:0];
          ovf_acc <= ovf_acc | add_ovf;
        end
        S_MUL_W1: begin
          if (mul_last) begin
            r1_r    <= mul_res;
            ovf_acc <= ovf_acc | mul_sat;
          end
        end
        S_MUL_W2: begin
          if (mul_last) begin
            r2_r    <= mul_res;
            ovf_acc <= ovf_acc | mul_sat;
          end
        end
        S_MUL_W3: begin
          if (mul_last) begin
            r3_r    <= mul_res;
            ovf_acc <= ovf_acc | mul_sat;
          end
        end
        S_MUL_W4: begin
          // Results publish as DONE is entered so Done and Busy overlap in the DONE cycle.
          if (mul_last) begin
            w1_q   <= r1_r;
            w2_q   <= r2_r;
            w3_q   <= r3_r;
            w4_q   <= mul_res;
            ovf_q  <= ovf_acc | mul_sat;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign INVERSE_KINEMATICS_W1_OutBus        = w1_q;
  assign INVERSE_KINEMATICS_W2_OutBus        = w2_q;
  assign INVERSE_KINEMATICS_W3_OutBus        = w3_q;
  assign INVERSE_KINEMATICS_W4_OutBus        = w4_q;
  assign INVERSE_KINEMATICS_Busy_OutHigh     = busy_q;
  assign INVERSE_KINEMATICS_Done_OutHigh     = done_q;
  assign INVERSE_KINEMATICS_Overflow_OutHigh = ovf_q;

endmodule

// File: tb/tb_inverse_kinematics.sv
// Directed bench for inverse_kinematics; outputs are sampled on the falling edge, so the value
// seen in the cycle ending at rising edge k is the value "at edge k" (Start-sampling edge = 0).
module tb_inverse_kinematics;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] vx, vy, wz;
  logic [31:0] w1, w2, w3, w4;
  logic        busy, done, ovf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inverse_kinematics dut (
    .INVERSE_KINEMATICS_CLOCK_50        (clk),
    .INVERSE_KINEMATICS_Reset_InHigh    (rst),
    .INVERSE_KINEMATICS_Start_InHigh    (start),
    .INVERSE_KINEMATICS_VX_InBus        (vx),
    .INVERSE_KINEMATICS_VY_InBus        (vy),
    .INVERSE_KINEMATICS_WZ_InBus        (wz),
    .INVERSE_KINEMATICS_W1_OutBus       (w1),
    .INVERSE_KINEMATICS_W2_OutBus       (w2),
    .INVERSE_KINEMATICS_W3_OutBus       (w3),
    .INVERSE_KINEMATICS_W4_OutBus       (w4),
    .INVERSE_KINEMATICS_Busy_OutHigh    (busy),
    .INVERSE_KINEMATICS_Done_OutHigh    (done),
    .INVERSE_KINEMATICS_Overflow_OutHigh(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Starts one computation, scrambles the inputs after the latch edge and waits for Done.
  task automatic run_op(input string tag, input logic [31:0] ivx, input logic [31:0] ivy,
                        input logic [31:0] iwz);
    int lat;
    @(negedge clk);
    vx = ivx; vy = ivy; wz = iwz; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    vx = 32'h1234_5678; vy = 32'h8765_4321; wz = 32'h0ABC_DEF0;
    chk($sformatf("%s_busy_edge1", tag), {31'b0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s_latency", tag), lat, 32'd157);
  endtask

  task automatic check_result(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [31:0] e4, input logic eovf);
    chk($sformatf("%s_w1", tag), w1, e1);
    chk($sformatf("%s_w2", tag), w2, e2);
    chk($sformatf("%s_w3", tag), w3, e3);
    chk($sformatf("%s_w4", tag), w4, e4);
    chk($sformatf("%s_ovf", tag), {31'b0, ovf}, {31'b0, eovf});
    chk($sformatf("%s_busy_in_done", tag), {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk($sformatf("%s_done_width", tag), {31'b0, done}, 32'd0);
    chk($sformatf("%s_busy_after", tag), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int nd, d1, d2, seen;
    rst = 1'b1; start = 1'b0; vx = '0; vy = '0; wz = '0;
    nd = 0; d1 = 0; d2 = 0; seen = 0;
    repeat (3) @(negedge clk);
    chk("reset_w1", w1, 32'h0);
    chk("reset_w4", w4, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 * 900219 >> 15 = 900219 = 0xDBC7B
    run_op("vx", 32'h0000_8000, 32'h0, 32'h0);
    check_result("vx", 32'h000D_BC7B, 32'h000D_BC7B, 32'h000D_BC7B, 32'h000D_BC7B, 1'b0);

    run_op("vy", 32'h0, 32'h0000_8000, 32'h0);
    check_result("vy", 32'h800D_BC7B, 32'h000D_BC7B, 32'h000D_BC7B, 32'h800D_BC7B, 1'b0);

    // t = 6554; 6554 * 900219 >> 15 = 180054 = 0x2BF56
    run_op("wz", 32'h0, 32'h0, 32'h0000_8000);
    check_result("wz", 32'h8002_BF56, 32'h0002_BF56, 32'h8002_BF56, 32'h0002_BF56, 1'b0);

    run_op("sat", 32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
    check_result("sat", 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);

    run_op("clr", 32'h0000_8000, 32'h0, 32'h0);
    check_result("clr", 32'h000D_BC7B, 32'h000D_BC7B, 32'h000D_BC7B, 32'h000D_BC7B, 1'b0);

    // Handshake: first run vx=-0.5 vy=0.25 wz=-1.0 -> s = -18022, -14746, -1638, -31130.
    @(negedge clk);
    vx = 32'h8000_4000; vy = 32'h0000_2000; wz = 32'h8000_8000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 320; n++) begin
      if (done) begin
        if (nd == 0) d1 = n;
        else         d2 = n;
        nd++;
      end
      if (n == 156) chk("hs_hold_w1_e156", w1, 32'h000D_BC7B);
      if (n == 157) begin
        chk("hs_mix_w1", w1, 32'h8007_8E05);
        chk("hs_mix_w2", w2, 32'h8006_2E75);
        chk("hs_mix_w3", w3, 32'h8000_AFC7);
        chk("hs_mix_w4", w4, 32'h800D_0CB3);
      end
      if (n == 200) begin
        chk("hs_hold_w1_e200", w1, 32'h8007_8E05);
        chk("hs_busy_e200", {31'b0, busy}, 32'd1);
      end
      if (n == 314) chk("hs_hold_w4_e314", w4, 32'h800D_0CB3);
      if (n == 315) begin
        chk("hs_wz_w1", w1, 32'h8002_BF56);
        chk("hs_wz_w2", w2, 32'h0002_BF56);
        chk("hs_wz_w3", w3, 32'h8002_BF56);
        chk("hs_wz_w4", w4, 32'h0002_BF56);
      end
      if (n == 50) begin
        start = 1'b1; vx = 32'h0; vy = 32'h0000_8000; wz = 32'h0;
      end
      if (n == 51) start = 1'b0;
      if (n == 150) begin
        start = 1'b1; vx = 32'h0; vy = 32'h0; wz = 32'h0000_8000;
      end
      if (n == 159) start = 1'b0;
      @(negedge clk);
    end
    chk("hs_done_count", nd, 32'd2);
    chk("hs_done_first", d1, 32'd157);
    chk("hs_done_second", d2, 32'd315);
    chk("hs_idle_end", {31'b0, busy}, 32'd0);

    // Reset in the middle of MUL_W2 must clear outputs at once and suppress Done.
    @(negedge clk);
    vx = 32'h0000_8000; vy = 32'h0; wz = 32'h0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (69) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_w1", w1, 32'h0);
    chk("arst_w2", w2, 32'h0);
    chk("arst_w3", w3, 32'h0);
    chk("arst_w4", w4, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ovf", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("arst_no_done", seen, 32'd0);
    chk("arst_idle", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inverse_kinematics.md
# inverse_kinematics

Computes mecanum-wheel inverse kinematics: it converts commanded local velocities (vx, vy, wz) into the four wheel angular velocities w1..w4. It sits between the trajectory/position controller and the per-wheel PID loops, and is the counterpart of the forward local-velocity block. Arithmetic is sign-magnitude fixed point (MSB = sign, Q fractional bits), the same format the qadd/qmults libraries use. One iterative multiplier is shared across a start/busy/done state machine.

## Interface
- N_WIDTH, 32, total word width (sign-magnitude)
- Q_WIDTH, 15, fractional bits
- K_LXLY, 32'd6554, lx+ly in meters (0.2 m), positive Q15 constant
- INV_R, 32'd900219, 1/r in 1/m (≈27.4725), positive Q15 constant
- INVERSE_KINEMATICS_CLOCK_50  in  1  system clock
- INVERSE_KINEMATICS_Reset_InHigh  in  1  reset, asynchronous and active-high
- INVERSE_KINEMATICS_Start_InHigh  in  1  level request, sampled only in IDLE
- INVERSE_KINEMATICS_VX_InBus  in  N_WIDTH  local vx [m/s]
- INVERSE_KINEMATICS_VY_InBus  in  N_WIDTH  local vy [m/s]
- INVERSE_KINEMATICS_WZ_InBus  in  N_WIDTH  local wz [rad/s]
- INVERSE_KINEMATICS_W1_OutBus .. W4_OutBus  out  N_WIDTH each  wheel speeds [rad/s], registered
- INVERSE_KINEMATICS_Busy_OutHigh  out  1  high whenever the state is not IDLE
- INVERSE_KINEMATICS_Done_OutHigh  out  1  one-cycle pulse when results update
- INVERSE_KINEMATICS_Overflow_OutHigh  out  1  a saturation occurred in the last completed computation

## Operation
- Equations, with t = K_LXLY·wz:
  - w1 = (vx − vy − t)·INV_R
  - w2 = (vx + vy + t)·INV_R
  - w3 = (vx + vy − t)·INV_R
  - w4 = (vx − vy + t)·INV_R
- States: IDLE → MUL_K → ADD → MUL_W1 → MUL_W2 → MUL_W3 → MUL_W4 → DONE → IDLE.
- IDLE: when Start=1 on an edge, latch VX/VY/WZ into internal registers, clear the internal overflow accumulator, and go to MUL_K.
- Input changes after the latch edge have no effect on the current computation.
- MUL_K: serial shift-add multiply of |wz|·K_LXLY, 1 magnitude bit per cycle, N_WIDTH−1 = 31 cycles.
  - Result = (product >> Q_WIDTH), truncated.
  - Sign = XOR of operand signs.
- ADD: in one cycle, form the four sums s1..s4 with sign-magnitude add/sub, as two chained adds per sum.
- MUL_Wi: 31 cycles each, si·INV_R, same multiply rules.
- DONE: load W1..W4 together, update Overflow from the accumulator, pulse Done, go to IDLE.
- Saturation rules:
  - A magnitude exceeding 2^(N_WIDTH−1)−1 at any add or multiply saturates to 0x7FFF_FFFF, keeping its sign.
  - Any saturation sets the accumulator.
- Negative zero is forbidden: a zero magnitude always gets sign 0.
- Start while Busy is ignored; no queueing.
- Holding Start high produces back-to-back computations.
- W1..W4 and Overflow hold their values between Done pulses.

## Timing
- Reset (asynchronous, any state): state becomes IDLE, W1..W4 = 0, Busy = 0, Done = 0, Overflow = 0, and internal registers clear.
- Reset mid-computation aborts the computation; no Done is produced.
- Latency: with the Start-sampling edge as edge 0:
  - MUL_K occupies edges 1–31.
  - ADD occurs at edge 32.
  - MUL_W1..W4 occupy edges 33–156.
  - DONE is entered at edge 157.
  - Outputs load and Done pulses on edge 157.
- Busy is high from edge 1 through the DONE cycle inclusive, and low again after edge 158.
- Start=1 at edge 158 (back in IDLE) is accepted, so the minimum period is 158 clocks.
- Start during the DONE cycle is ignored.
- Done and Busy are both high during the DONE cycle.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset check: assert reset mid-MUL_W2 (edge ~70) → W1..W4 = 0, Busy = 0, Overflow = 0 immediately (asynchronously), and no Done follows.
- Pure vx: vx = 0x00008000 (1.0), vy = wz = 0 → at edge 157, W1..W4 = 0x000DBC7B, Done is high for exactly 1 cycle, Overflow = 0.
- Pure vy: vy = 0x00008000, others 0 → W1 = W4 = 0x800DBC7B, W2 = W3 = 0x000DBC7B.
- Pure wz: wz = 0x00008000, others 0 → t = 6554, W1 = W3 = 0x8002BF56, W2 = W4 = 0x0002BF56.
- Saturation: vx = vy = 0x7FFF0000, wz = 0 → W2 = W3 = 0x7FFFFFFF, W1 = W4 = 0x00000000 (sign 0), Overflow = 1.
  - A following run with vx = 1.0 clears Overflow to 0.
- Handshake: pulse Start at edge 0, again at edge 50, and hold Start high from edge 150.
  - The edge-50 request is ignored.
  - Done pulses at edges 157 and 315.
  - Results change only on those edges.
